// File: rtl/commit_unit_pkg.sv
// Shared types and helpers for the commit unit.
//  - rob_entry_t : one reorder-buffer slot (pc, waddr, wdata, wen, ppreg, valid)
//  - is_younger  : program-order age compare relative to the ROB head
package commit_unit_pkg;

  // Upper bounds so one package serves every parameterisation of the unit.
  localparam int unsigned SeqMaxBits  = 16;
  localparam int unsigned PregMaxBits = 8;

  typedef struct packed {
    logic [31:0]            pc;
    logic [4:0]             waddr;
    logic [31:0]            wdata;
    logic                   wen;
    logic [PregMaxBits-1:0] ppreg;
    logic                   valid;
  } rob_entry_t;

  // age(x) = (x - head) mod 2**bits; s is younger than q iff age(s) > age(q).
  function automatic logic is_younger(input logic [SeqMaxBits-1:0] s,
                                      input logic [SeqMaxBits-1:0] q,
                                      input logic [SeqMaxBits-1:0] head,
                                      input int unsigned           bits);
    logic [SeqMaxBits-1:0] mask;
    logic [SeqMaxBits-1:0] age_s;
    logic [SeqMaxBits-1:0] age_q;
    mask  = (SeqMaxBits'(1) << bits) - SeqMaxBits'(1);
    age_s = (s - head) & mask;
    age_q = (q - head) & mask;
    return age_s > age_q;
  endfunction

endpackage

// File: rtl/commit_unit_rr_arbiter.sv
// Round-robin arbiter.
//  clk, rst : clock, synchronous active-high reset (priority -> requester 0)
//  req      : request vector
//  en       : grant was consumed this cycle; priority advances past the winner
//  gnt      : one-hot grant; with no requests it points at the priority slot
module rr_arbiter #(
  parameter int unsigned p_width = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [p_width-1:0] req,
  input  logic               en,
  output logic [p_width-1:0] gnt
);

  localparam int unsigned PtrBits = (p_width > 1) ? $clog2(p_width) : 1;

  logic [PtrBits-1:0] ptr_q, ptr_d;
  logic [PtrBits-1:0] win;

  always_comb begin
    int unsigned idx;
    logic        found;
    idx   = 0;
    found = 1'b0;
    win   = ptr_q;
    for (int unsigned i = 0; i < p_width; i++) begin
      idx = (32'(ptr_q) + i) % p_width;
      if (!found && req[idx]) begin
        win   = PtrBits'(idx);
        found = 1'b1;
      end
    end
    gnt = p_width'(1) << win;

    ptr_d = ptr_q;
    if (en) begin
      ptr_d = (win == PtrBits'(p_width - 1)) ? '0 : win + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/commit_unit.sv
// Writeback/commit stage.
//  X_*          : per-pipe completed results (flattened, pipe i at slice i)
//  X_rdy        : one-hot round-robin grant, low during reset
//  complete_*   : combinational broadcast of the accepted result
//  commit_*     : in-order retirement from the ROB head, one per cycle
//  squash_*     : discard entries younger than squash_seq_num
module commit_unit
  import commit_unit_pkg::*;
#(
  parameter  int unsigned p_num_pipes      = 3,
  parameter  int unsigned p_seq_num_bits   = 5,
  parameter  int unsigned p_num_phys_regs  = 36,
  localparam int unsigned p_phys_addr_bits = $clog2(p_num_phys_regs)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [p_num_pipes-1:0]                 X_val,
  output logic [p_num_pipes-1:0]                 X_rdy,
  input  logic [p_num_pipes*32-1:0]              X_pc,
  input  logic [p_num_pipes*p_seq_num_bits-1:0]  X_seq_num,
  input  logic [p_num_pipes*5-1:0]               X_waddr,
  input  logic [p_num_pipes*32-1:0]              X_wdata,
  input  logic [p_num_pipes-1:0]                 X_wen,
  input  logic [p_num_pipes*p_phys_addr_bits-1:0] X_preg,
  input  logic [p_num_pipes*p_phys_addr_bits-1:0] X_ppreg,
  output logic                                   complete_val,
  output logic [p_seq_num_bits-1:0]              complete_seq_num,
  output logic [4:0]                             complete_waddr,
  output logic [31:0]                            complete_wdata,
  output logic                                   complete_wen,
  output logic [p_phys_addr_bits-1:0]            complete_preg,
  output logic                                   commit_val,
  output logic [31:0]                            commit_pc,
  output logic [p_seq_num_bits-1:0]              commit_seq_num,
  output logic [4:0]                             commit_waddr,
  output logic [31:0]                            commit_wdata,
  output logic                                   commit_wen,
  output logic [p_phys_addr_bits-1:0]            commit_ppreg,
  input  logic                                   squash_val,
  input  logic [p_seq_num_bits-1:0]              squash_seq_num,
  input  logic [31:0]                            squash_target
);

  localparam int unsigned RobDepth = 2 ** p_seq_num_bits;

  logic [p_num_pipes-1:0]      gnt;
  logic                        accept;
  logic                        drop;
  logic                        write;

  logic [31:0]                 s_pc;
  logic [p_seq_num_bits-1:0]   s_seq;
  logic [4:0]                  s_waddr;
  logic [31:0]                 s_wdata;
  logic                        s_wen;
  logic [p_phys_addr_bits-1:0] s_preg;
  logic [p_phys_addr_bits-1:0] s_ppreg;

  logic [p_seq_num_bits-1:0]   head_q, head_d;
  rob_entry_t                  rob_q [RobDepth];
  rob_entry_t                  rob_d [RobDepth];
  rob_entry_t                  head_e;

  logic                        unused_bits;

  rr_arbiter #(
    .p_width (p_num_pipes)
  ) u_arb (
    .clk (clk),
    .rst (rst),
    .req (X_val),
    .en  (accept),
    .gnt (gnt)
  );

  assign X_rdy  = rst ? '0 : gnt;
  assign accept = |(X_val & X_rdy);

  // Mux the granted pipe's fields.
  always_comb begin
    s_pc    = '0;
    s_seq   = '0;
    s_waddr = '0;
    s_wdata = '0;
    s_wen   = 1'b0;
    s_preg  = '0;
    s_ppreg = '0;
    for (int i = 0; i < int'(p_num_pipes); i++) begin
      if (gnt[i]) begin
        s_pc    = X_pc[i*32 +: 32];
        s_seq   = X_seq_num[i*p_seq_num_bits +: p_seq_num_bits];
        s_waddr = X_waddr[i*5 +: 5];
        s_wdata = X_wdata[i*32 +: 32];
        s_wen   = X_wen[i];
        s_preg  = X_preg[i*p_phys_addr_bits +: p_phys_addr_bits];
        s_ppreg = X_ppreg[i*p_phys_addr_bits +: p_phys_addr_bits];
      end
    end
  end

  // A result younger than a same-cycle squash is handshaken but discarded.
  assign drop  = squash_val && is_younger(SeqMaxBits'(s_seq), SeqMaxBits'(squash_seq_num),
                                          SeqMaxBits'(head_q), p_seq_num_bits);
  assign write = accept && !drop;

  assign complete_val     = write;
  assign complete_seq_num = s_seq;
  assign complete_waddr   = s_waddr;
  assign complete_wdata   = s_wdata;
  assign complete_wen     = s_wen;
  assign complete_preg    = s_preg;

  assign head_e         = rob_q[head_q];
  assign commit_val     = !rst && head_e.valid;
  assign commit_pc      = head_e.pc;
  assign commit_seq_num = head_q;
  assign commit_waddr   = head_e.waddr;
  assign commit_wdata   = head_e.wdata;
  assign commit_wen     = head_e.wen;
  assign commit_ppreg   = head_e.ppreg[p_phys_addr_bits-1:0];

  assign unused_bits = ^{squash_target, head_e.ppreg};

  always_comb begin
    rob_d  = rob_q;
    head_d = head_q;

    if (commit_val) begin
      rob_d[head_q].valid = 1'b0;
      head_d              = head_q + 1'b1;
    end

    // The head is never younger than anything, so an in-flight commit survives.
    if (squash_val) begin
      for (int i = 0; i < int'(RobDepth); i++) begin
        if (rob_q[i].valid && is_younger(SeqMaxBits'(i), SeqMaxBits'(squash_seq_num),
                                         SeqMaxBits'(head_q), p_seq_num_bits)) begin
          rob_d[i].valid = 1'b0;
        end
      end
    end

    if (write) begin
      rob_d[s_seq].pc    = s_pc;
      rob_d[s_seq].waddr = s_waddr;
      rob_d[s_seq].wdata = s_wdata;
      rob_d[s_seq].wen   = s_wen;
      rob_d[s_seq].ppreg = PregMaxBits'(s_ppreg);
      rob_d[s_seq].valid = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      for (int i = 0; i < int'(RobDepth); i++) begin
        rob_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      rob_q  <= rob_d;
      if (write) begin
        assert (!rob_q[s_seq].valid)
          else $error("commit_unit: result written into occupied rob slot %0d", s_seq);
      end
    end
  end

endmodule

// File: tb/tb_commit_unit.sv
module tb_commit_unit;

  localparam int unsigned NP  = 3;
  localparam int unsigned SB  = 3;
  localparam int unsigned PR  = 36;
  localparam int unsigned PAB = 6;

  logic                clk = 1'b0;
  logic                rst;
  logic [NP-1:0]       X_val;
  logic [NP-1:0]       X_rdy;
  logic [NP*32-1:0]    X_pc;
  logic [NP*SB-1:0]    X_seq_num;
  logic [NP*5-1:0]     X_waddr;
  logic [NP*32-1:0]    X_wdata;
  logic [NP-1:0]       X_wen;
  logic [NP*PAB-1:0]   X_preg;
  logic [NP*PAB-1:0]   X_ppreg;
  logic                complete_val;
  logic [SB-1:0]       complete_seq_num;
  logic [4:0]          complete_waddr;
  logic [31:0]         complete_wdata;
  logic                complete_wen;
  logic [PAB-1:0]      complete_preg;
  logic                commit_val;
  logic [31:0]         commit_pc;
  logic [SB-1:0]       commit_seq_num;
  logic [4:0]          commit_waddr;
  logic [31:0]         commit_wdata;
  logic                commit_wen;
  logic [PAB-1:0]      commit_ppreg;
  logic                squash_val;
  logic [SB-1:0]       squash_seq_num;
  logic [31:0]         squash_target;

  commit_unit #(
    .p_num_pipes     (NP),
    .p_seq_num_bits  (SB),
    .p_num_phys_regs (PR)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .X_val            (X_val),
    .X_rdy            (X_rdy),
    .X_pc             (X_pc),
    .X_seq_num        (X_seq_num),
    .X_waddr          (X_waddr),
    .X_wdata          (X_wdata),
    .X_wen            (X_wen),
    .X_preg           (X_preg),
    .X_ppreg          (X_ppreg),
    .complete_val     (complete_val),
    .complete_seq_num (complete_seq_num),
    .complete_waddr   (complete_waddr),
    .complete_wdata   (complete_wdata),
    .complete_wen     (complete_wen),
    .complete_preg    (complete_preg),
    .commit_val       (commit_val),
    .commit_pc        (commit_pc),
    .commit_seq_num   (commit_seq_num),
    .commit_waddr     (commit_waddr),
    .commit_wdata     (commit_wdata),
    .commit_wen       (commit_wen),
    .commit_ppreg     (commit_ppreg),
    .squash_val       (squash_val),
    .squash_seq_num   (squash_seq_num),
    .squash_target    (squash_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SB-1:0]  seq;
    logic [31:0]    pc;
    logic [4:0]     waddr;
    logic [31:0]    wdata;
    logic           wen;
    logic [PAB-1:0] preg;
    logic [PAB-1:0] ppreg;
  } exp_t;

  exp_t complete_q[$];
  exp_t commit_q[$];
  int   total = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  function automatic exp_t mk(input int seq, input int tag);
    exp_t e;
    e.seq   = SB'(seq);
    e.pc    = 32'h1000 + 32'(tag) * 4;
    e.waddr = 5'(tag + 1);
    e.wdata = 32'hA500_0000 | 32'(tag);
    e.wen   = (tag % 2) == 0;
    e.preg  = PAB'(tag % 36);
    e.ppreg = PAB'((tag + 11) % 36);
    return e;
  endfunction

  task automatic clr();
    X_val      = '0;
    squash_val = 1'b0;
  endtask

  task automatic send(input int p, input exp_t e, input logic push_complete);
    X_val[p]              = 1'b1;
    X_pc[p*32 +: 32]      = e.pc;
    X_seq_num[p*SB +: SB] = e.seq;
    X_waddr[p*5 +: 5]     = e.waddr;
    X_wdata[p*32 +: 32]   = e.wdata;
    X_wen[p]              = e.wen;
    X_preg[p*PAB +: PAB]  = e.preg;
    X_ppreg[p*PAB +: PAB] = e.ppreg;
    if (push_complete) complete_q.push_back(e);
  endtask

  // Pop and compare whatever the DUT broadcast or retired this cycle.
  task automatic sample();
    exp_t e;
    if (complete_val === 1'b1) begin
      chk("complete_expected", 32'(complete_q.size() != 0), 1);
      if (complete_q.size() != 0) begin
        e = complete_q.pop_front();
        chk("complete_seq",   32'(complete_seq_num), 32'(e.seq));
        chk("complete_waddr", 32'(complete_waddr),   32'(e.waddr));
        chk("complete_wdata", complete_wdata,        e.wdata);
        chk("complete_wen",   32'(complete_wen),     32'(e.wen));
        chk("complete_preg",  32'(complete_preg),    32'(e.preg));
      end
    end
    if (commit_val === 1'b1) begin
      chk("commit_expected", 32'(commit_q.size() != 0), 1);
      if (commit_q.size() != 0) begin
        e = commit_q.pop_front();
        chk("commit_seq",   32'(commit_seq_num), 32'(e.seq));
        chk("commit_pc",    commit_pc,           e.pc);
        chk("commit_waddr", 32'(commit_waddr),   32'(e.waddr));
        chk("commit_wdata", commit_wdata,        e.wdata);
        chk("commit_wen",   32'(commit_wen),     32'(e.wen));
        chk("commit_ppreg", 32'(commit_ppreg),   32'(e.ppreg));
      end
    end
  endtask

  task automatic settle();
    #1;
    sample();
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (commit_q.size() != 0 && n < 20) begin
      settle();
      next();
      n++;
    end
    chk(tag, 32'(commit_q.size()), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    exp_t e, e0, e1, e2, e3, e7;

    rst            = 1'b1;
    X_pc           = '0;
    X_seq_num      = '0;
    X_waddr        = '0;
    X_wdata        = '0;
    X_wen          = '0;
    X_preg         = '0;
    X_ppreg        = '0;
    squash_seq_num = '0;
    squash_target  = '0;
    clr();

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_rdy",      32'(X_rdy),        0);
    chk("rst_complete", 32'(complete_val), 0);
    chk("rst_commit",   32'(commit_val),   0);
    next();
    rst = 1'b0;
    #1;
    chk("idle_rdy",    32'(X_rdy),      32'b001);
    chk("idle_commit", 32'(commit_val), 0);
    next();

    // In order: single result, commit one cycle later
    e = '{seq: 3'd0, pc: 32'h0000_1000, waddr: 5'd5, wdata: 32'h2A, wen: 1'b1,
          preg: 6'd9, ppreg: 6'd7};
    clr();
    send(0, e, 1'b1);
    commit_q.push_back(e);
    settle();
    chk("t1_rdy",          32'(X_rdy),        32'b001);
    chk("t1_complete_val", 32'(complete_val), 1);
    chk("t1_commit_early", 32'(commit_val),   0);
    next();
    clr();
    settle();
    chk("t1_commit_val", 32'(commit_val), 1);
    next();

    // Out of order: head=1, arrive 3,2,1, retire 1,2,3 back to back
    e3 = mk(3, 10);
    e2 = mk(2, 11);
    e1 = mk(1, 12);
    clr(); send(1, e3, 1'b1); settle();
    chk("t2_complete_val", 32'(complete_val), 1);
    chk("t2_hold_a", 32'(commit_val), 0);
    next();
    clr(); send(1, e2, 1'b1); settle();
    chk("t2_hold_b", 32'(commit_val), 0);
    next();
    clr(); send(2, e1, 1'b1); settle();
    chk("t2_hold_c", 32'(commit_val), 0);
    next();
    commit_q.push_back(e1);
    commit_q.push_back(e2);
    commit_q.push_back(e3);
    clr();
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("t2_commit_burst", 32'(commit_val), 1);
      next();
    end
    settle();
    chk("t2_after", 32'(commit_val), 0);
    next();

    // Arbitration: priority back at pipe 0, all pipes valid (head=4)
    clr();
    send(0, mk(4, 30), 1'b1);
    send(1, mk(5, 31), 1'b1);
    send(2, mk(6, 32), 1'b1);
    commit_q.push_back(mk(4, 30));
    commit_q.push_back(mk(5, 31));
    commit_q.push_back(mk(6, 32));
    settle();
    chk("t3_gnt0", 32'(X_rdy), 32'b001);
    next();
    X_val[0] = 1'b0;
    settle();
    chk("t3_gnt1", 32'(X_rdy), 32'b010);
    next();
    X_val[1] = 1'b0;
    settle();
    chk("t3_gnt2", 32'(X_rdy), 32'b100);
    next();
    clr();
    drain("t3_drain");

    // Squash: head=7; fill 2 (h+3), 0 (h+1), 7 (h); squash at 0 with 3 arriving
    e2 = mk(2, 20);
    e0 = mk(0, 21);
    e7 = mk(7, 22);
    e3 = mk(3, 23);
    clr(); send(0, e2, 1'b1); settle(); next();
    clr(); send(1, e0, 1'b1); settle(); next();
    clr(); send(2, e7, 1'b1); settle(); next();
    commit_q.push_back(e7);
    commit_q.push_back(e0);
    clr();
    send(0, e3, 1'b0);
    squash_val     = 1'b1;
    squash_seq_num = 3'd0;
    settle();
    chk("t4_drop_rdy",      32'(X_rdy),        32'b001);
    chk("t4_drop_complete", 32'(complete_val), 0);
    chk("t4_commit_older",  32'(commit_val),   1);
    next();
    clr();
    settle();
    chk("t4_commit_squasher", 32'(commit_val), 1);
    next();
    // Refill 1; slot 2 must have been cleared so retirement stops at 1
    e1 = mk(1, 24);
    clr(); send(1, e1, 1'b1); commit_q.push_back(e1); settle(); next();
    clr();
    for (int k = 0; k < 3; k++) begin
      settle();
      if (k > 0) chk("t4_squashed_gone", 32'(commit_val), 0);
      next();
    end
    // Refill 2; dropped 3 must not exist
    e2 = mk(2, 25);
    clr(); send(2, e2, 1'b1); commit_q.push_back(e2); settle(); next();
    clr();
    for (int k = 0; k < 3; k++) begin
      settle();
      if (k > 0) chk("t4_dropped_gone", 32'(commit_val), 0);
      next();
    end
    drain("t4_drain");

    // Wrap: head=3, stream 12 results through the 7->0 boundary
    for (int k = 0; k < 12; k++) begin
      e = mk((3 + k) % 8, 40 + k);
      clr();
      send(k % 3, e, 1'b1);
      commit_q.push_back(e);
      settle();
      chk("wrap_complete", 32'(complete_val), 1);
      if (k > 0) chk("wrap_commit_gapless", 32'(commit_val), 1);
      next();
    end
    clr();
    settle();
    chk("wrap_last", 32'(commit_val), 1);
    next();
    settle();
    chk("wrap_idle", 32'(commit_val), 0);
    next();
    drain("wrap_drain");

    // Reset mid-run: head=7, slots 1,2 occupied and stuck behind the head
    clr(); send(0, mk(1, 60), 1'b1); settle(); next();
    clr(); send(1, mk(2, 61), 1'b1); settle();
    chk("rm_hold", 32'(commit_val), 0);
    next();
    rst = 1'b1;
    clr();
    send(2, mk(0, 62), 1'b0);
    settle();
    chk("rm_rdy",      32'(X_rdy),        0);
    chk("rm_complete", 32'(complete_val), 0);
    chk("rm_commit",   32'(commit_val),   0);
    next();
    rst = 1'b0;
    clr();
    settle();
    chk("rm_post_commit", 32'(commit_val), 0);
    chk("rm_post_rdy",    32'(X_rdy),      32'b001);
    next();
    e0 = mk(0, 63);
    clr(); send(0, e0, 1'b1); commit_q.push_back(e0); settle(); next();
    clr();
    settle();
    chk("rm_commit_seq0", 32'(commit_val), 1);
    next();
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("rm_no_stale", 32'(commit_val), 0);
      next();
    end

    chk("final_commit_q",   32'(commit_q.size()),   0);
    chk("final_complete_q", 32'(complete_q.size()), 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/commit_unit.md
Name: commit_unit

Overview:
- Writeback/commit stage directly downstream of the execute pipes fed by the decode-issue unit.
- Accepts completed instructions from `p_num_pipes` execute pipes, one per cycle through round-robin arbitration.
- Broadcasts each accepted instruction as a complete notification so issue can wake up and forward operands.
- Holds results in a seq_num-indexed reorder buffer and emits commit notifications strictly in program order, one per cycle.
- Consumes squash notifications to discard results younger than the squashing instruction.

Parameters:
- p_num_pipes, 3, number of execute pipes feeding this block
- p_seq_num_bits, 5, sequence-number width; ROB depth = 2**p_seq_num_bits
- p_num_phys_regs, 36, physical register count; p_phys_addr_bits = $clog2(p_num_phys_regs)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- X_val  in  p_num_pipes  per-pipe result valid
- X_rdy  out  p_num_pipes  per-pipe result ready
- X_pc  in  p_num_pipes x 32  instruction pc
- X_seq_num  in  p_num_pipes x p_seq_num_bits  sequence number
- X_waddr  in  p_num_pipes x 5  architectural destination
- X_wdata  in  p_num_pipes x 32  result data
- X_wen  in  p_num_pipes  register write enable
- X_preg  in  p_num_pipes x p_phys_addr_bits  destination physical register
- X_ppreg  in  p_num_pipes x p_phys_addr_bits  previous physical mapping of waddr
- complete_val/seq_num/waddr/wdata/wen/preg  out  1/p_seq_num_bits/5/32/1/p_phys_addr_bits  completion broadcast
- commit_val/pc/seq_num/waddr/wdata/wen/ppreg  out  1/32/p_seq_num_bits/5/32/1/p_phys_addr_bits  in-order commit
- squash_val  in  1  squash request
- squash_seq_num  in  p_seq_num_bits  squashing instruction
- squash_target  in  32  redirect target (unused here)

Behaviour:
- Reset: head=0; all ROB valid bits=0; arbiter priority=pipe 0; complete_val=0; commit_val=0; X_rdy=0 while rst is high.
- Arbitration:
  - Exactly one X_rdy bit is high per cycle: the round-robin winner among valid pipes.
  - If no pipe is valid, X_rdy = one-hot of the current priority pointer.
  - After an accept (val&rdy), priority moves to winner+1 mod p_num_pipes.
- Complete broadcast:
  - Combinational in the accept cycle.
  - complete_val = accept, fields taken from the winning pipe.
  - A dropped (squashed) accept does not raise complete_val.
- ROB write:
  - On accept, the entry at index seq_num latches pc, waddr, wdata, wen, ppreg and sets valid (next edge).
  - Upstream guarantees at most 2**p_seq_num_bits instructions in flight, so no full stall exists.
  - A write into an already-valid entry is a protocol error; flag it with an assertion.
- Commit:
  - Registered. commit_val=1 in cycle N iff entry[head] was valid at the edge ending cycle N-1.
  - At most one commit per cycle.
  - Fields come from the registered head entry; on commit, entry[head] is cleared and head = head+1 mod 2**p_seq_num_bits (wrap from all-ones to 0).
  - An entry written at edge N is committed in cycle N+1 at the earliest.
  - Empty ROB (entry[head] invalid): commit_val=0, head holds.
- Age: age(s) = (s - head) mod 2**p_seq_num_bits. s is younger than q iff age(s) > age(q).
- Squash:
  - On squash_val, every valid entry younger than squash_seq_num is cleared at the next edge.
  - The squashing instruction itself and all older entries are kept.
  - An accept in the same cycle whose seq_num is younger is dropped: X_rdy is still given, nothing is written, complete_val=0.
  - An accept of an older entry proceeds normally.
  - Squash does not move head.
  - A commit in the same cycle of an older entry proceeds.
- Reset mid-operation: all entries and in-flight state are discarded at the reset edge.

Decomposition:
- Shared package: p_seq_num_bits-derived age-compare function; ROB entry struct (pc, waddr, wdata, wen, ppreg, valid).
- Sub-module: rr_arbiter (parameter p_width; ports clk, rst, req, en, gnt), reused by other multi-pipe blocks.

Test Plan:
- In order: pipe0 sends seq 0 (waddr 5, wdata 0x2A, wen 1, ppreg 7) -> complete_val same cycle; commit seq 0 next cycle with wdata 0x2A, ppreg 7.
- Out of order: seq 2 then seq 1 then seq 0 on successive cycles -> no commit until seq 0 lands; commits 0,1,2 on three consecutive cycles.
- Arbitration: all three pipes valid with seq 0,1,2 simultaneously -> grants pipe0, pipe1, pipe2 in consecutive cycles; complete order 0,1,2.
- Squash: seq 0,1,3 in ROB, squash_seq_num=1 with seq 4 arriving the same cycle -> seq 3 cleared, seq 4 dropped with complete_val=0; commits 0,1 only.
- Wrap: p_seq_num_bits=3, stream seq 0..7 then 0..3 -> head wraps from 7 to 0; 12 commits in order with no gaps.
- Reset mid-run: ROB holding seq 4,5 with head=4, assert rst -> commit_val=0 next cycle; after reset, seq 0 commits normally.
